dmem_arbiter: RTL and testbench

Sequencer and two-port arbiter for the single-port 64-bit data memory. It sits between the memory stage of the processor (port 0) and the program loader/debug port (port 1). It grants one requester at a time, performs address-range checking, and drives a one-cycle memory strobe. It then waits the fixed memory latency and returns read data or an error with a one-cycle acknowledge.

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port sequencer/arbiter for the single-port 64-bit data memory.
// Port 0 is the processor memory stage, port 1 is the loader/debug port.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin between the ports when
// both request). When undefined, port 0 has fixed priority.
// Handshake: a requester holds pN_req (with stable-enough fields until grant)
// until it sees pN_ack=1, and clears req on that same clock edge; fields are
// sampled only when the arbiter is IDLE, and exactly one ack follows each grant.
module dmem_arbiter #(
  parameter longint unsigned ADDR_LIMIT = 64'd8192,
  parameter int unsigned     LAT        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [63:0] p0_addr,
  input  logic [63:0] p0_wdata,
  output logic        p0_ack,
  output logic [63:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [63:0] p1_addr,
  input  logic [63:0] p1_wdata,
  output logic        p1_ack,
  output logic [63:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_grant;   // 0 = port 0 owns the transaction, 1 = port 1
  logic        r_we;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_data;
  logic        r_err;
  logic [3:0]  r_cnt;

  logic        w_any;
  logic        w_winner;
  logic        w_in_range;
  logic        w_resp;

  assign w_any      = p0_req | p1_req;
  assign w_in_range = (r_addr < ADDR_LIMIT);

`ifdef DMEM_ARB_RR_EN
  logic r_ptr;            // preferred port when both request

  // Round-robin pick: the pointer only matters on contention
  always_comb begin
    w_winner = 1'b0;
    if (p0_req && p1_req) w_winner = r_ptr;
    else                  w_winner = p1_req;
  end

  // Pointer moves to the other port after every grant; reset favours port 0
  always_ff @(posedge clk) begin
    if (rst)                              r_ptr <= 1'b0;
    else if (r_state == S_IDLE && w_any)  r_ptr <= ~w_winner;
  end
`else
  // Fixed priority: port 0 wins whenever it requests
  always_comb begin
    w_winner = ~p0_req;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: w_next = w_in_range ? S_WAIT : S_RESP;
      S_WAIT:   if (r_cnt <= 4'd1) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Transaction registers: latch on grant, count latency, capture the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_data  <= 64'd0;
      r_err   <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_winner;
            r_we    <= w_winner ? p1_we    : p0_we;
            r_addr  <= w_winner ? p1_addr  : p0_addr;
            r_wdata <= w_winner ? p1_wdata : p0_wdata;
            r_err   <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (w_in_range) begin
            r_cnt <= 4'(LAT);
          end else begin
            r_err  <= 1'b1;
            r_data <= 64'd0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          // Writes return zero data so the ack carries no stale read value
          if (r_cnt <= 4'd1) r_data <= r_we ? 64'd0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state so reset forces every one of them to zero
  assign mem_en    = (r_state == S_ACCESS) && w_in_range;
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = mem_en ? r_addr  : 64'd0;
  assign mem_wdata = mem_en ? r_wdata : 64'd0;

  assign w_resp    = (r_state == S_RESP);
  assign p0_ack    = w_resp & ~r_grant;
  assign p1_ack    = w_resp &  r_grant;
  assign p0_rdata  = p0_ack ? r_data : 64'd0;
  assign p1_rdata  = p1_ack ? r_data : 64'd0;
  assign p0_err    = p0_ack & r_err;
  assign p1_err    = p1_ack & r_err;

  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, table-driven bench for dmem_arbiter (LAT=2,
// ADDR_LIMIT=8192) with a small behavioural memory of 256 words.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p0_ack, p0_err;
  logic [63:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_ack, p1_err;
  logic [63:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_en, mem_we, busy;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  dmem_arbiter #(.ADDR_LIMIT(64'd8192), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model: 2-cycle read latency ----------------
  logic [63:0] mem [0:255];
  logic [63:0] r_d1, r_d2;
  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 64'h0123_4567_89AB_CDEF;
      mem[5] <= 64'hDEAD_BEEF_0000_0001;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    r_d1 <= mem[mem_addr[7:0]];
    r_d2 <= r_d1;
  end
  assign mem_rdata = r_d2;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Protocol monitor: strobe never two cycles in a row, acks never together
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en) check("mem_en_single_cycle", 64'(prev_en), 64'd0);
      if (p0_ack || p1_ack) check("ack_exclusive", 64'(p0_ack & p1_ack), 64'd0);
    end
    prev_en = mem_en;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one request on a port, wait (bounded) for its ack and check it.
  // Called #1 after a rising edge with the arbiter idle.
  task automatic run_txn(input string name, input logic port, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic exp_err, input logic [63:0] exp_rdata);
    int k, ack_k, en_k, en_cnt;
    logic [63:0] en_addr, got_rdata, exp_d;
    logic en_we, got_err, other_ack;
    ack_k = -1; en_k = -1; en_cnt = 0; en_addr = 64'd0; en_we = 1'b0;
    got_rdata = 64'd0; got_err = 1'b0; other_ack = 1'b0;
    exp_q.push_back(exp_rdata);
    if (port == 1'b0) begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end
    k = 0;
    while (ack_k < 0 && k < 32) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (en_k < 0) begin en_k = k; en_addr = mem_addr; en_we = mem_we; end
      end
      if (port == 1'b0) begin
        if (p1_ack) other_ack = 1'b1;
        if (p0_ack) begin ack_k = k; got_rdata = p0_rdata; got_err = p0_err; end
      end else begin
        if (p0_ack) other_ack = 1'b1;
        if (p1_ack) begin ack_k = k; got_rdata = p1_rdata; got_err = p1_err; end
      end
      @(posedge clk); #1;
      if (ack_k >= 0) begin p0_req = 1'b0; p1_req = 1'b0; end
      k++;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    check({name, "_ack_cycle"}, 64'(ack_k), exp_err ? 64'd2 : 64'd4);
    check({name, "_mem_en_count"}, 64'(en_cnt), exp_err ? 64'd0 : 64'd1);
    if (!exp_err) begin
      check({name, "_mem_en_cycle"}, 64'(en_k), 64'd1);
      check({name, "_mem_addr"}, en_addr, addr);
      check({name, "_mem_we"}, 64'(en_we), 64'(we));
    end
    exp_d = exp_q.pop_front();
    check({name, "_rdata"}, got_rdata, exp_d);
    check({name, "_err"}, 64'(got_err), 64'(exp_err));
    check({name, "_other_ack"}, 64'(other_ack), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        port;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input string n, input logic port, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic exp_err, input logic [63:0] exp_rdata);
    vec_t v;
    v.name = n; v.port = port; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    vecs.push_back(v);
  endtask

  // Failsafe so the bench always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  logic exp_seq [8];
  logic got_seq [8];
  int   n, rem0, rem1, acks, first_port;

  initial begin
    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;

    add_vec("rd_p0_a5",       1'b0, 1'b0, 64'd5,    64'd0,      1'b0, 64'hDEAD_BEEF_0000_0001);
    add_vec("wr_p1_a100",     1'b1, 1'b1, 64'd100,  64'h1234,   1'b0, 64'd0);
    add_vec("rd_p1_a100",     1'b1, 1'b0, 64'd100,  64'd0,      1'b0, 64'h1234);
    add_vec("rd_p0_a8192",    1'b0, 1'b0, 64'd8192, 64'd0,      1'b1, 64'd0);
    add_vec("rd_p0_aff",      1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0);
    add_vec("wr_p0_a8191",    1'b0, 1'b1, 64'd8191, 64'hA5A5,   1'b0, 64'd0);
    add_vec("rd_p0_a8191",    1'b0, 1'b0, 64'd8191, 64'd0,      1'b0, 64'hA5A5);
    add_vec("wr_p1_a2pow63",  1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h77, 1'b1, 64'd0);
    add_vec("rd_p1_a0",       1'b1, 1'b0, 64'd0,    64'd0,      1'b0, 64'h0123_4567_89AB_CDEF);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {mem_en, mem_we, p0_ack, p0_err, p1_ack, p1_err, busy},  64'd0);
    check("rst_buses", mem_addr | mem_wdata | p0_rdata | p1_rdata, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Table-driven single transactions
    for (int i = 0; i < vecs.size(); i++)
      run_txn(vecs[i].name, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_err, vecs[i].exp_rdata);

    // Contention: both ports issue 4 reads each, re-requesting immediately
`ifdef DMEM_ARB_RR_EN
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    n = 0; rem0 = 4; rem1 = 4;
    p0_we = 0; p0_addr = 64'd10; p1_we = 0; p1_addr = 64'd11;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int c = 0; c < 200 && n < 8; c++) begin
      @(negedge clk);
      if (p0_ack && n < 8) begin got_seq[n] = 1'b0; n++; rem0--; end
      if (p1_ack && n < 8) begin got_seq[n] = 1'b1; n++; rem1--; end
      @(posedge clk); #1;
      p0_req = (rem0 > 0); p1_req = (rem1 > 0);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    check("contention_grant_count", 64'(n), 64'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("contention_grant_%0d", i), 64'(got_seq[i]), 64'(exp_seq[i]));

    // Reset during WAIT: one p0 grant first so the pointer would favour p1
    run_txn("pre_abort_rd", 1'b0, 1'b0, 64'd5, 64'd0, 1'b0, 64'hDEAD_BEEF_0000_0001);
    p0_we = 0; p0_addr = 64'd5; p0_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_mem_en", 64'(mem_en), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; p0_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_mem_en_low", 64'(mem_en), 64'd0);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      if (p0_ack || p1_ack) acks++;
      @(negedge clk);
    end
    check("abort_no_ack", 64'(acks), 64'd0);
    @(posedge clk); #1;

    run_txn("post_abort_p1", 1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF);

    // Simultaneous request after the abort: port 0 goes first
    p0_we = 0; p0_addr = 64'd5; p1_we = 0; p1_addr = 64'd0;
    p0_req = 1'b1; p1_req = 1'b1;
    first_port = -1; acks = 0;
    for (int c = 0; c < 40 && acks < 2; c++) begin
      @(negedge clk);
      if (p0_ack) begin if (first_port < 0) first_port = 0; acks++; end
      if (p1_ack) begin if (first_port < 0) first_port = 1; acks++; end
      @(posedge clk); #1;
      if (p0_ack_seen(first_port, 0)) p0_req = 1'b0;
      if (first_port >= 0 && acks == 2) p1_req = 1'b0;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    check("post_abort_first_grant", 64'(first_port), 64'd0);
    check("post_abort_both_served", 64'(acks), 64'd2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // True once the given port has received its ack in the simultaneous sequence
  function automatic bit p0_ack_seen(input int fp, input int port);
    return (fp == port);
  endfunction

endmodule
